clock_set_ctrl: RTL and testbench

//  Time-set controller between the key debouncers, the HHMMSS time counter and the 6-digit display driver.

---
 rtl/clock_set_ctrl.sv | 159 +++++++++++++++
 tb/tb_clock_set_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// Time-set controller: RUN passes live HHMMSS to the display; SET_HOUR/MIN/SET_SEC edit fields and load the counter.
// Optional blinking of the selected field's points is enabled by defining CLOCK_SET_BLINK_EN.
module clock_set_ctrl #(
    parameter int BLINK_CNT   = 25_000_000,
    parameter int TIMEOUT_CYC = 500_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_mode,
    input  logic        key_inc,
    input  logic        key_dec,
    input  logic [19:0] cur_time,
    output logic        run_en,
    output logic        load_en,
    output logic [19:0] load_data,
    output logic [19:0] data,
    output logic [5:0]  point,
    output logic        en,
    output logic        sign
);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN, SET_SEC} state_t;

    state_t           state_reg, state_next;
    logic [4:0]       hh_reg, hh_next;
    logic [5:0]       mm_reg, mm_next;
    logic [5:0]       ss_reg, ss_next;
    logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
    logic             key_any, edit_up, edit_dn, tmo_hit, load_next;
    logic [4:0]       cap_hh;
    logic [5:0]       cap_mm, cap_ss;
    logic [19:0]      composed_next;
    logic [2:0]       field_sel;
    logic [5:0]       point_mask;
    logic             blink_on;

    assign key_any = key_mode | key_inc | key_dec;
    // Mode has priority; simultaneous inc+dec cancel each other.
    assign edit_up = key_inc & ~key_dec & ~key_mode;
    assign edit_dn = key_dec & ~key_inc & ~key_mode;
    assign tmo_hit = (tmo_cnt_reg == TMO_W'(TIMEOUT_CYC - 1));

    assign cap_hh = 5'(cur_time / 20'd10000);
    assign cap_mm = 6'((cur_time / 20'd100) % 20'd100);
    assign cap_ss = 6'(cur_time % 20'd100);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:      if (key_mode) state_next = SET_HOUR;
            SET_HOUR: if (key_mode) state_next = SET_MIN;
                      else if (!key_any && tmo_hit) state_next = RUN;
            SET_MIN:  if (key_mode) state_next = SET_SEC;
                      else if (!key_any && tmo_hit) state_next = RUN;
            SET_SEC:  if (key_mode) state_next = RUN;
                      else if (!key_any && tmo_hit) state_next = RUN;
            default:  state_next = RUN;
        endcase
    end

    always_comb begin
        hh_next = hh_reg;
        mm_next = mm_reg;
        ss_next = ss_reg;
        if (state_reg == RUN && key_mode) begin
            hh_next = cap_hh;
            mm_next = cap_mm;
            ss_next = cap_ss;
        end else if (edit_up || edit_dn) begin
            case (state_reg)
                SET_HOUR: hh_next = edit_up ? ((hh_reg == 5'd23) ? 5'd0 : hh_reg + 5'd1)
                                            : ((hh_reg == 5'd0) ? 5'd23 : hh_reg - 5'd1);
                SET_MIN:  mm_next = edit_up ? ((mm_reg == 6'd59) ? 6'd0 : mm_reg + 6'd1)
                                            : ((mm_reg == 6'd0) ? 6'd59 : mm_reg - 6'd1);
                SET_SEC:  ss_next = edit_up ? ((ss_reg == 6'd59) ? 6'd0 : ss_reg + 6'd1)
                                            : ((ss_reg == 6'd0) ? 6'd59 : ss_reg - 6'd1);
                default:  ;
            endcase
        end
    end

    assign load_next     = (state_reg == SET_SEC) && key_mode;
    assign tmo_cnt_next  = (state_next == RUN || key_any) ? '0 : tmo_cnt_reg + TMO_W'(1);
    assign composed_next = 20'(hh_next) * 20'd10000 + 20'(mm_next) * 20'd100 + 20'(ss_next);
    assign field_sel     = {state_next == SET_HOUR, state_next == SET_MIN, state_next == SET_SEC};

    // field_sel[0]=SS drives point[1:0], [1]=MM drives [3:2], [2]=HH drives [5:4]
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_point
            assign point_mask[2*gi +: 2] = {2{field_sel[gi]}};
        end
    endgenerate

`ifdef CLOCK_SET_BLINK_EN
    localparam int BLK_W = $clog2(BLINK_CNT + 1);

    logic [BLK_W-1:0] blink_cnt_reg, blink_cnt_next;
    logic             phase_reg, phase_next;

    // A key press restarts a full lit half-period so the edit shows immediately.
    always_comb begin
        blink_cnt_next = blink_cnt_reg + BLK_W'(1);
        phase_next     = phase_reg;
        if (key_any) begin
            blink_cnt_next = '0;
            phase_next     = 1'b1;
        end else if (blink_cnt_reg == BLK_W'(BLINK_CNT - 1)) begin
            blink_cnt_next = '0;
            phase_next     = ~phase_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_reg <= '0;
            phase_reg     <= 1'b1;
        end else begin
            blink_cnt_reg <= blink_cnt_next;
            phase_reg     <= phase_next;
        end
    end

    assign blink_on = phase_next;
`else
    // Steady points; the blink period parameter has no effect in this build.
    assign blink_on = (BLINK_CNT > 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= RUN;
            hh_reg      <= '0;
            mm_reg      <= '0;
            ss_reg      <= '0;
            tmo_cnt_reg <= '0;
            run_en      <= 1'b0;
            load_en     <= 1'b0;
            load_data   <= '0;
            data        <= '0;
            point       <= '0;
            en          <= 1'b0;
            sign        <= 1'b0;
        end else begin
            state_reg   <= state_next;
            hh_reg      <= hh_next;
            mm_reg      <= mm_next;
            ss_reg      <= ss_next;
            tmo_cnt_reg <= tmo_cnt_next;
            run_en      <= (state_next == RUN);
            load_en     <= load_next;
            load_data   <= load_next ? composed_next : load_data;
            data        <= (state_next == RUN) ? cur_time : composed_next;
            point       <= point_mask & {6{blink_on}};
            en          <= 1'b1;
            sign        <= 1'b0;
        end
    end
endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed key sequences, a field-level model checked every cycle, and literal pins.
// Follows the CLOCK_SET_BLINK_EN build setting of the design.
module tb_clock_set_ctrl;
    localparam int BLK = 4;
    localparam int TMO = 20;
`ifdef CLOCK_SET_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, key_mode, key_inc, key_dec;
    logic [19:0] cur_time;
    logic        run_en, load_en, en, sign;
    logic [19:0] load_data, data;
    logic [5:0]  point;

    int n_tests = 0;
    int n_fail  = 0;
    int n_load  = 0;

    clock_set_ctrl #(.BLINK_CNT(BLK), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .key_mode(key_mode), .key_inc(key_inc), .key_dec(key_dec),
        .cur_time(cur_time), .run_en(run_en), .load_en(load_en), .load_data(load_data),
        .data(data), .point(point), .en(en), .sign(sign)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model state: mode 0=RUN 1=hour 2=min 3=sec; fields hh,mm,ss as plain integers
    int          m_mode, m_idle, m_bcnt;
    bit          m_phase;
    int          m_f[3];
    logic        e_run_en, e_load_en, e_en, e_sign;
    logic [19:0] e_load_data, e_data;
    logic [5:0]  e_point;

    always @(posedge clk) begin : model
        automatic int mode = m_mode;
        automatic int idle = m_idle;
        automatic int bc   = m_bcnt;
        automatic bit ph   = m_phase;
        automatic int f[3];
        automatic bit ld   = 1'b0;
        automatic int cur, sel, lim, comp;
        automatic bit lit;
        f = m_f;
        if (rst) begin
            m_mode <= 0; m_idle <= 0; m_bcnt <= 0; m_phase <= 1'b1;
            m_f <= '{0, 0, 0};
            e_run_en <= 0; e_load_en <= 0; e_en <= 0; e_sign <= 0;
            e_load_data <= '0; e_data <= '0; e_point <= '0;
        end else begin
            cur = int'(cur_time);
            if (mode == 0) begin
                if (key_mode) begin
                    f[0] = cur / 10000; f[1] = (cur / 100) % 100; f[2] = cur % 100;
                    mode = 1; idle = 0;
                end
            end else if (key_mode) begin
                if (mode == 3) begin ld = 1'b1; mode = 0; end
                else mode = mode + 1;
                idle = 0;
            end else if (key_inc != key_dec) begin
                sel = mode - 1;
                lim = (sel == 0) ? 24 : 60;
                f[sel] = key_inc ? (f[sel] + 1) % lim : (f[sel] + lim - 1) % lim;
                idle = 0;
            end else if (key_inc) begin
                idle = 0;
            end else begin
                idle = idle + 1;
                if (idle >= TMO) begin mode = 0; idle = 0; end
            end
            if (key_mode || key_inc || key_dec) begin ph = 1'b1; bc = 0; end
            else begin
                bc = bc + 1;
                if (bc == BLK) begin ph = !ph; bc = 0; end
            end
            comp = f[0] * 10000 + f[1] * 100 + f[2];
            lit  = BLINK_ON ? ph : 1'b1;
            m_mode <= mode; m_idle <= idle; m_bcnt <= bc; m_phase <= ph; m_f <= f;
            e_en <= 1'b1; e_sign <= 1'b0;
            e_run_en  <= (mode == 0);
            e_load_en <= ld;
            if (ld) e_load_data <= 20'(comp);
            e_data  <= (mode == 0) ? cur_time : 20'(comp);
            e_point <= (mode == 0 || !lit) ? 6'd0 : 6'(3 << (2 * (3 - mode)));
        end
    end

    initial begin : compare
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("cyc_run_en", 32'(run_en), 32'(e_run_en));
            check("cyc_load_en", 32'(load_en), 32'(e_load_en));
            check("cyc_load_data", 32'(load_data), 32'(e_load_data));
            check("cyc_data", 32'(data), 32'(e_data));
            check("cyc_point", 32'(point), 32'(e_point));
            check("cyc_en", 32'(en), 32'(e_en));
            check("cyc_sign", 32'(sign), 32'(e_sign));
        end
    end

    always @(posedge clk) begin
        #2;
        if (load_en === 1'b1) n_load <= n_load + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit m, input bit i, input bit d);
        key_mode = m; key_inc = i; key_dec = d;
        @(negedge clk);
        key_mode = 1'b0; key_inc = 1'b0; key_dec = 1'b0;
    endtask

    initial begin : stim
        int base;
        rst = 1'b1; key_mode = 1'b0; key_inc = 1'b0; key_dec = 1'b0;
        cur_time = 20'd123456;
        tick(3);
        check("rst_data", 32'(data), 32'd0);
        check("rst_en", 32'(en), 32'd0);
        check("rst_run_en", 32'(run_en), 32'd0);
        check("rst_point", 32'(point), 32'd0);
        rst = 1'b0;
        tick(1);
        check("post_rst_en", 32'(en), 32'd1);
        check("post_rst_run_en", 32'(run_en), 32'd1);
        check("post_rst_data", 32'(data), 32'd123456);

        press(0, 1, 0);
        check("run_inc_ignored", 32'(data), 32'd123456);

        cur_time = 20'd235959;
        press(1, 0, 0);
        check("enter_set_run_en", 32'(run_en), 32'd0);
        check("enter_set_data", 32'(data), 32'd235959);
        press(0, 1, 0);
        check("hh_wrap_data", 32'(data), 32'd5959);
        check("hh_point", 32'(point), 32'b110000);

        press(1, 0, 0);
        press(0, 1, 0);
        check("mm_inc_wrap", 32'(data), 32'd59);
        press(0, 0, 1);
        check("mm_dec_wrap", 32'(data), 32'd5959);
        for (int k = 0; k < 8; k++) begin
            check("mm_point_phase", 32'(point), (BLINK_ON && k >= 4) ? 32'd0 : 32'b001100);
            tick(1);
        end
        tick(4);
        check("mm_point_late", 32'(point), BLINK_ON ? 32'd0 : 32'b001100);
        press(0, 1, 0);
        check("mm_point_forced", 32'(point), 32'b001100);
        press(0, 0, 1);
        press(1, 0, 0);
        base = n_load;
        press(1, 0, 0);
        check("load1_en", 32'(load_en), 32'd1);
        check("load1_data", 32'(load_data), 32'd5959);
        check("load1_run_en", 32'(run_en), 32'd1);
        tick(3);
        check("load1_count", 32'(n_load - base), 32'd1);

        cur_time = 20'd101010;
        press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
        check("ss_point", 32'(point), 32'b000011);
        press(0, 1, 1);
        check("ss_both_ignored", 32'(data), 32'd101010);
        press(0, 1, 0);
        check("ss_inc", 32'(data), 32'd101011);
        base = n_load;
        press(1, 1, 0);
        check("load2_en", 32'(load_en), 32'd1);
        check("load2_data", 32'(load_data), 32'd101011);
        tick(2);
        check("load2_count", 32'(n_load - base), 32'd1);

        cur_time = 20'd5;
        press(1, 0, 0);
        press(0, 0, 1);
        check("hh_dec_wrap", 32'(data), 32'd230005);
        base = n_load;
        rst = 1'b1;
        tick(1);
        check("midrst_data", 32'(data), 32'd0);
        check("midrst_load_en", 32'(load_en), 32'd0);
        check("midrst_point", 32'(point), 32'd0);
        rst = 1'b0;
        tick(1);
        check("midrst_after_run", 32'(run_en), 32'd1);
        check("midrst_after_data", 32'(data), 32'd5);
        tick(2);
        check("midrst_no_load", 32'(n_load - base), 32'd0);

        cur_time = 20'd120000;
        press(1, 0, 0);
        base = n_load;
        tick(TMO - 1);
        check("tmo_before", 32'(run_en), 32'd0);
        tick(1);
        check("tmo_run_en", 32'(run_en), 32'd1);
        check("tmo_data", 32'(data), 32'd120000);
        check("tmo_point", 32'(point), 32'd0);
        cur_time = 20'd120001;
        tick(1);
        check("tmo_follow", 32'(data), 32'd120001);
        check("tmo_no_load", 32'(n_load - base), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
